// File: rtl/pcileech_rstctl_pkg.sv
// Shared types and default constants for the PCILeech reset/button controller.
// Reset sequencer state encoding plus counter-sizing helpers.
package pcileech_rstctl_pkg;

    typedef enum logic [1:0] {
        S_POR     = 2'd0,
        S_RUN     = 2'd1,
        S_HOLD    = 2'd2,
        S_STRETCH = 2'd3
    } rstctl_state_t;

    localparam int unsigned DEF_POR_CYCLES      = 64;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_STRETCH_CYCLES  = 64;
    localparam int unsigned DEF_HEARTBEAT_BIT   = 26;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pcileech_rstctl_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer for one raw button.
// The debounced level only follows the synchronized level after it has differed for DEBOUNCE_CYCLES.
module pcileech_debounce
    import pcileech_rstctl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_db
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any return to the accepted level restarts the hold window.
            if (r_sync2 != r_db) begin
                if (r_cnt == LAST) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/pcileech_rstctl.sv
// System reset sequencer, button debounce, tick counter and heartbeat LED for the PCILeech top.
// Optional PCIe PERST# input is enabled with `define PCILEECH_RSTCTL_PERST_EN.
module pcileech_rstctl
    import pcileech_rstctl_pkg::*;
#(
    parameter int unsigned POR_CYCLES      = DEF_POR_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
    parameter int unsigned HEARTBEAT_BIT   = DEF_HEARTBEAT_BIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_rst,
    input  logic        btn_inv,
`ifdef PCILEECH_RSTCTL_PERST_EN
    input  logic        pcie_rst_n,
`endif
    output logic        rst,
    output logic        ft601_rst_n,
    output logic        btn_inv_db,
    output logic        led_heartbeat,
    output logic [63:0] tickcount
);

    localparam int unsigned CW = cnt_width(max_u(POR_CYCLES, STRETCH_CYCLES));
    localparam logic [CW-1:0] POR_LAST     = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);

    logic          w_db_rst;
    logic          w_db_inv;
    logic          w_req;
    rstctl_state_t r_state;
    rstctl_state_t w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;
    logic          r_rst;
    logic          r_ft601_rst_n;
    logic          r_led;
    logic [63:0]   r_tick;

    pcileech_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_raw   (btn_rst),
        .o_db    (w_db_rst)
    );

    pcileech_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inv (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_raw   (btn_inv),
        .o_db    (w_db_inv)
    );

`ifdef PCILEECH_RSTCTL_PERST_EN
    // PERST# is already clean from the host; synchronize only, no debounce.
    logic r_perst_sync1;
    logic r_perst_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perst_sync1 <= 1'b1;
            r_perst_sync2 <= 1'b1;
        end else begin
            r_perst_sync1 <= pcie_rst_n;
            r_perst_sync2 <= r_perst_sync1;
        end
    end

    assign w_req = w_db_rst | ~r_perst_sync2;
`else
    assign w_req = w_db_rst;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_POR: begin
                if (r_cnt == POR_LAST) begin
                    w_next_cnt   = '0;
                    w_next_state = w_req ? S_HOLD : S_RUN;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                w_next_cnt = '0;
                if (w_req) w_next_state = S_HOLD;
            end
            S_HOLD: begin
                w_next_cnt = '0;
                if (!w_req) w_next_state = S_STRETCH;
            end
            S_STRETCH: begin
                if (w_req) begin
                    w_next_state = S_HOLD;
                    w_next_cnt   = '0;
                end else if (r_cnt == STRETCH_LAST) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_POR;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_POR;
            r_cnt         <= '0;
            r_rst         <= 1'b1;
            r_ft601_rst_n <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_rst         <= (w_next_state != S_RUN);
            r_ft601_rst_n <= (w_next_state == S_RUN);
        end
    end

    // Tick keeps running through system reset; only the block reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick <= '0;
            r_led  <= 1'b0;
        end else begin
            r_tick <= r_tick + 64'd1;
            r_led  <= r_tick[HEARTBEAT_BIT] | w_db_rst | w_db_inv;
        end
    end

    assign rst           = r_rst;
    assign ft601_rst_n   = r_ft601_rst_n;
    assign btn_inv_db    = w_db_inv;
    assign led_heartbeat = r_led;
    assign tickcount     = r_tick;

endmodule
